// File: rtl/onehot_scan_encoder.sv
// onehot_scan_encoder: captures a request vector and emits one beat per set bit, in priority order
module onehot_scan_encoder #(
  parameter int WIDTH = 16,
  parameter int IDX_W = $clog2(WIDTH),
  parameter bit LSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_vec,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_last,
  output logic             out_zero,
  output logic [IDX_W:0]   out_count
);
  typedef enum logic {IDLE, EMIT} state_t;
  state_t state, state_n;
  logic [WIDTH-1:0] pending, pending_n;
  logic [IDX_W-1:0] idx_n;
  logic [IDX_W:0] count_n;
  logic cap, xfer, last_n, zero_n;
  function automatic logic [IDX_W-1:0] pick(input logic [WIDTH-1:0] v);
    pick = '0;
    for (int i = 0; i < WIDTH; i++)
      if (v[LSB_FIRST ? WIDTH-1-i : i]) pick = IDX_W'(LSB_FIRST ? WIDTH-1-i : i);
  endfunction
  function automatic logic [IDX_W:0] pop(input logic [WIDTH-1:0] v);
    pop = '0;
    for (int i = 0; i < WIDTH; i++) pop = pop + (IDX_W+1)'(v[i]);
  endfunction
  assign in_ready  = state == IDLE;
  assign out_valid = state == EMIT;
  // outputs are precomputed from the next pending vector so every field is registered
  always_comb begin
    cap = enable && in_valid && state == IDLE;
    xfer = enable && out_ready && state == EMIT;
    pending_n = cap ? in_vec : xfer ? pending & ~(WIDTH'(1) << out_idx) : pending;
    state_n = cap ? EMIT : (xfer && out_last) ? IDLE : state;
    idx_n = state_n == EMIT ? pick(pending_n) : '0;
    last_n = state_n == EMIT && (pending_n & (pending_n - WIDTH'(1))) == '0;
    zero_n = state_n == EMIT && pending_n == '0;
    count_n = cap ? pop(in_vec) : state_n == EMIT ? out_count : '0;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      pending <= '0;
      out_idx <= '0;
      out_last <= 1'b0;
      out_zero <= 1'b0;
      out_count <= '0;
    end else begin
      state <= state_n;
      pending <= pending_n;
      out_idx <= idx_n;
      out_last <= last_n;
      out_zero <= zero_n;
      out_count <= count_n;
    end
  end
endmodule

// File: tb/tb_onehot_scan_encoder.sv
// tb_onehot_scan_encoder: LSB-first and MSB-first instances driven in lockstep against a queue model
module tb_onehot_scan_encoder;
  localparam int W = 16;
  logic clk = 0, rst_n = 0, enable = 1, in_valid = 0, out_ready = 1;
  logic [W-1:0] in_vec = '0;
  logic rdy[2], vld[2], last[2], zero[2];
  logic [3:0] idx[2];
  logic [4:0] cnt[2];
  int checks = 0, errors = 0;
  int q[2][$];
  bit busy[2], zf[2], was_rst;
  int mcnt[2];
  always #5 clk = ~clk;
  onehot_scan_encoder #(.WIDTH(W), .LSB_FIRST(1)) u_lsb (
    .clk(clk), .rst_n(rst_n), .enable(enable), .in_valid(in_valid), .in_ready(rdy[0]),
    .in_vec(in_vec), .out_valid(vld[0]), .out_ready(out_ready), .out_idx(idx[0]),
    .out_last(last[0]), .out_zero(zero[0]), .out_count(cnt[0]));
  onehot_scan_encoder #(.WIDTH(W), .LSB_FIRST(0)) u_msb (
    .clk(clk), .rst_n(rst_n), .enable(enable), .in_valid(in_valid), .in_ready(rdy[1]),
    .in_vec(in_vec), .out_valid(vld[1]), .out_ready(out_ready), .out_idx(idx[1]),
    .out_last(last[1]), .out_zero(zero[1]), .out_count(cnt[1]));
  task automatic chk(input string tag, input int m, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s[%0d] observed=%0h expected=%0h", tag, m, obs, exp);
    end
  endtask
  task automatic model();
    was_rst = !rst_n;
    for (int m = 0; m < 2; m++) begin
      if (!rst_n) begin
        q[m] = {};
        busy[m] = 0;
        zf[m] = 0;
        mcnt[m] = 0;
      end else if (enable && busy[m] && out_ready) begin
        void'(q[m].pop_front());
        busy[m] = q[m].size() > 0;
      end else if (enable && !busy[m] && in_valid) begin
        mcnt[m] = $countones(in_vec);
        zf[m] = in_vec == 0;
        if (zf[m]) q[m].push_back(0);
        for (int i = 0; i < W; i++)
          if (in_vec[i]) begin
            if (m == 0) q[m].push_back(i); else q[m].push_front(i);
          end
        busy[m] = 1;
      end
    end
  endtask
  task automatic check_all();
    for (int m = 0; m < 2; m++) begin
      chk("in_ready", m, rdy[m], !busy[m]);
      chk("out_valid", m, vld[m], busy[m]);
      if (busy[m]) begin
        chk("out_idx", m, idx[m], q[m][0]);
        chk("out_last", m, last[m], q[m].size() == 1);
        chk("out_zero", m, zero[m], zf[m]);
        chk("out_count", m, cnt[m], mcnt[m]);
      end else if (was_rst) begin
        chk("rst_idx", m, idx[m], 0);
        chk("rst_last", m, last[m], 0);
        chk("rst_zero", m, zero[m], 0);
        chk("rst_count", m, cnt[m], 0);
      end
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    model();
    #1 check_all();
  endtask
  task automatic send(input logic [W-1:0] v);
    in_valid = 1;
    in_vec = v;
    cyc();
    in_valid = 0;
    in_vec = W'($urandom);
  endtask
  task automatic drain(input bit toggle);
    int n = 0;
    while ((vld[0] || vld[1]) && n < 100) begin
      if (toggle) out_ready = n[0] == 0;
      cyc();
      n++;
    end
    out_ready = 1;
    if (n >= 100) chk("drain_timeout", 0, 1, 0);
    cyc();
  endtask
  initial begin
    cyc();
    cyc();
    rst_n = 1;
    cyc();
    send(16'h0008);
    drain(0);
    send(16'h8421);
    drain(0);
    send(16'h8421);
    drain(1);
    send(16'h0000);
    drain(0);
    send(16'hFFFF);
    repeat (4) cyc();
    enable = 0;
    in_valid = 1;
    repeat (3) cyc();
    in_valid = 0;
    enable = 1;
    drain(0);
    send(16'h00F0);
    cyc();
    rst_n = 0;
    cyc();
    rst_n = 1;
    repeat (3) cyc();
    for (int k = 0; k < 600; k++) begin
      in_valid = $urandom_range(0, 3) != 0;
      in_vec = $urandom_range(0, 7) == 0 ? W'(0) : $urandom_range(0, 7) == 0 ? W'('1) : W'($urandom);
      out_ready = $urandom_range(0, 3) != 0;
      enable = $urandom_range(0, 7) != 0;
      rst_n = $urandom_range(0, 99) != 0;
      cyc();
    end
    rst_n = 1;
    enable = 1;
    in_valid = 0;
    drain(0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
